fp_mul_pipe: RTL and testbench
==============================

Name: fp_mul_pipe

Overview:
- Parametrised IEEE-754-style floating-point multiplier; successor to the single-stage CNN multiplier.
- Three-stage pipeline with valid/ready handshake and round-to-nearest-even.
- Full special-case handling (zero, inf, NaN, denormal flush) and exception flags.
- Sits between CNN operand fetch and the accumulator; back-pressure from the accumulator stalls the whole pipe.

Parameters:
- EXPONENT_WIDTH, 5: exponent field width; bias = 2^(EXPONENT_WIDTH-1)-1.
- MANTISSA_WIDTH, 10: stored fraction width (hidden bit implicit).
- W (derived, not overridable), EXPONENT_WIDTH+MANTISSA_WIDTH+1: word width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  pipe can accept; transfer when in_valid&&in_ready
- flp_a  in  W  operand A {sign, exponent, fraction}
- flp_b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts; transfer when out_valid&&out_ready
- result  out  W  packed product
- flags  out  4  [3] invalid, [2] overflow, [1] underflow, [0] inexact; qualified by out_valid

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0; out_valid=0, result=0, flags=0. in_ready is 1 from the first cycle after reset release. Reset mid-operation discards in-flight data; no partial result emerges.
- Pipeline enable: adv = !out_valid || out_ready; in_ready = adv. When adv=0, every stage register holds (global stall); no bubble squeezing.
- Latency: exactly 3 clk edges from accepting transfer to out_valid with out_ready held high. Throughput is 1 per cycle.
- S1, unpack/classify: sign = sa^sb. Class per operand: ZERO (exp=0, any fraction; denormals flush to zero), INF (exp all-ones, frac=0), NAN (exp all-ones, frac!=0), NORM. Signed exponent sum e = ea+eb-bias, computed at width EXPONENT_WIDTH+2.
- S2, multiply: p = {1,fa}*{1,fb}, width 2*MANTISSA_WIDTH+2. Pass class, sign and e.
- S3, normalise/round/pack:
  - If p MSB=1, shift right 1 and e+1.
  - Guard = first dropped bit; sticky = OR of the rest. RNE: round up if guard && (sticky || lsb).
  - Round carry-out renormalises (fraction=0, e+1).
  - inexact = guard||sticky.
- Range checks:
  - e >= 2^EXPONENT_WIDTH-1: result = signed inf; overflow=1, inexact=1.
  - e <= 0: result = signed zero; underflow=1, inexact=1.
- Specials take priority over arithmetic:
  - NAN in, or INF*ZERO: canonical NaN (sign 0, exp all-ones, frac MSB=1, rest 0); invalid=1 only for INF*ZERO.
  - INF*NORM or INF*INF: signed inf, no flags.
  - ZERO*finite: signed zero (sign = sa^sb, -0 preserved), no flags.
- result and flags are registered; they change only on the cycle out_valid is (re)asserted with new data, and hold while stalled.

Decomposition:
- Package fp_pkg: bias function, class enum {ZERO, NORM, INF, NAN}, flag index constants, canonical-NaN constructor.
- Sub-module fp_unpack: combinational classify, holding sign, exponent, hidden-bit mantissa and class; instantiated twice in S1.

Test Plan (defaults, half precision; flags shown as binary [3:0]):
- 0x3E00*0x3E00 (1.5*1.5) with out_ready=1 -> after 3 cycles result=0x4080, flags=0000.
- RNE: 0x3C01*0x3C01 -> 0x3C02, flags=0001. Tie: 0x3C01*0x3E00 -> 0x3E02, flags=0001.
- Overflow: 0x7BFF*0x4000 -> 0x7C00, flags=0101. Underflow: 0x0400*0x3800 -> 0x0000, flags=0011.
- Specials:
  - 0x7C00*0x0000 -> 0x7E00, flags=1000.
  - 0x8000*0x3C00 -> 0x8000, flags=0000.
  - 0xFC00*0x4000 -> 0xFC00, flags=0000.
- Back-pressure: stream 6 pairs with in_valid=1 and out_ready low for cycles 4-7. Require in_ready=0 while out_valid&&!out_ready, no loss or duplication, in-order results, and result stable during the stall.
- Assert rst_n=0 with 2 items in flight -> out_valid=0 immediately; after release the first accepted pair emerges exactly 3 cycles later, with no stale output.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fp_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  localparam int unsigned FLAG_W         = 4;
  localparam int unsigned FLAG_INVALID   = 3;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_INEXACT   = 0;

  localparam int unsigned MAX_W = 64;

  function automatic int unsigned fp_bias(input int unsigned ew);
    return (32'd1 << (ew - 32'd1)) - 32'd1;
  endfunction

  // Quiet NaN: sign 0, exponent all-ones, fraction MSB set; caller truncates to W.
  function automatic logic [MAX_W-1:0] fp_canon_nan(input int unsigned ew, input int unsigned mw);
    logic [MAX_W-1:0] v;
    v = (((MAX_W'(1) << ew) - MAX_W'(1)) << mw) | (MAX_W'(1) << (mw - 32'd1));
    return v;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle between operand fetch, multiplier and accumulator.
interface fp_mul_pipe_if #(
  parameter int unsigned EXPONENT_WIDTH = 5,
  parameter int unsigned MANTISSA_WIDTH = 10
);
  import fp_pkg::*;

  localparam int unsigned W = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      flp_a;
  logic [W-1:0]      flp_b;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      result;
  logic [FLAG_W-1:0] flags;

  modport master (
    output in_valid, flp_a, flp_b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, flp_a, flp_b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_unpack.sv
// Combinational field split and classification of one operand; denormals flush to zero.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int unsigned EXPONENT_WIDTH = 5,
  parameter int unsigned MANTISSA_WIDTH = 10
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] flp,
  output logic                                   sign,
  output logic [EXPONENT_WIDTH-1:0]              exp_f,
  output logic [MANTISSA_WIDTH:0]                mant,
  output fp_class_e                              cls
);
  localparam int unsigned W = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;

  logic [MANTISSA_WIDTH-1:0] frac;

  always_comb begin
    sign  = flp[W-1];
    exp_f = flp[W-2 -: EXPONENT_WIDTH];
    frac  = flp[MANTISSA_WIDTH-1:0];
    mant  = {1'b1, frac};
    cls   = CLS_NORM;
    if (exp_f == '0)
      cls = CLS_ZERO;
    else if (exp_f == '1)
      cls = (frac == '0) ? CLS_INF : CLS_NAN;
  end
endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier (unpack, multiply, normalise/round) with global stall.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXPONENT_WIDTH = 5,
  parameter int unsigned MANTISSA_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  fp_mul_pipe_if.slave bus
);
  localparam int unsigned EW   = EXPONENT_WIDTH;
  localparam int unsigned MW   = MANTISSA_WIDTH;
  localparam int unsigned W    = EW + MW + 1;
  localparam int unsigned EXW  = EW + 2;
  localparam int unsigned PW   = 2 * MW + 2;
  localparam int unsigned BIAS = fp_bias(EW);
  localparam logic signed [EXW-1:0] E_MAX = EXW'((32'd1 << EW) - 32'd1);

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // S1 operand classification
  logic            ua_sign, ub_sign;
  logic [EW-1:0]   ua_exp, ub_exp;
  logic [MW:0]     ua_mant, ub_mant;
  fp_class_e       ua_cls, ub_cls;

  fp_unpack #(.EXPONENT_WIDTH(EW), .MANTISSA_WIDTH(MW)) u_unpack_a (
    .flp(bus.flp_a), .sign(ua_sign), .exp_f(ua_exp), .mant(ua_mant), .cls(ua_cls)
  );
  fp_unpack #(.EXPONENT_WIDTH(EW), .MANTISSA_WIDTH(MW)) u_unpack_b (
    .flp(bus.flp_b), .sign(ub_sign), .exp_f(ub_exp), .mant(ub_mant), .cls(ub_cls)
  );

  logic                  s1_valid, s1_sign;
  logic signed [EXW-1:0] s1_e;
  logic [MW:0]           s1_ma, s1_mb;
  fp_class_e             s1_cls_a, s1_cls_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_e     <= '0;
      s1_ma    <= '0;
      s1_mb    <= '0;
      s1_cls_a <= CLS_ZERO;
      s1_cls_b <= CLS_ZERO;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign  <= ua_sign ^ ub_sign;
        s1_e     <= EXW'(ua_exp) + EXW'(ub_exp) - EXW'(BIAS);
        s1_ma    <= ua_mant;
        s1_mb    <= ub_mant;
        s1_cls_a <= ua_cls;
        s1_cls_b <= ub_cls;
      end
    end
  end

  // S2 significand product
  logic                  s2_valid, s2_sign;
  logic signed [EXW-1:0] s2_e;
  logic [PW-1:0]         s2_p;
  fp_class_e             s2_cls_a, s2_cls_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_e     <= '0;
      s2_p     <= '0;
      s2_cls_a <= CLS_ZERO;
      s2_cls_b <= CLS_ZERO;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign  <= s1_sign;
        s2_e     <= s1_e;
        s2_p     <= PW'(s1_ma) * PW'(s1_mb);
        s2_cls_a <= s1_cls_a;
        s2_cls_b <= s1_cls_b;
      end
    end
  end

  // S3 normalise, round-to-nearest-even, range check and special-case override
  logic [PW-2:0]         p_n;
  logic signed [EXW-1:0] e_n, e_r;
  logic [MW-1:0]         frac;
  logic [MW:0]           frac_r;
  logic                  guard, sticky, round_up, inexact;
  logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inf_zero;
  logic [W-1:0]          res_c;
  logic [FLAG_W-1:0]     flg_c;

  always_comb begin
    p_n      = s2_p[PW-1] ? s2_p[PW-2:0] : {s2_p[PW-3:0], 1'b0};
    e_n      = s2_e + EXW'(s2_p[PW-1]);
    frac     = p_n[PW-2 -: MW];
    guard    = p_n[PW-2-MW];
    sticky   = |p_n[PW-3-MW:0];
    round_up = guard && (sticky || frac[0]);
    frac_r   = {1'b0, frac} + (MW+1)'(round_up);
    e_r      = e_n + EXW'(frac_r[MW]);
    inexact  = guard || sticky;

    a_nan    = (s2_cls_a == CLS_NAN);
    b_nan    = (s2_cls_b == CLS_NAN);
    a_inf    = (s2_cls_a == CLS_INF);
    b_inf    = (s2_cls_b == CLS_INF);
    a_zero   = (s2_cls_a == CLS_ZERO);
    b_zero   = (s2_cls_b == CLS_ZERO);
    inf_zero = (a_inf && b_zero) || (a_zero && b_inf);

    res_c = {s2_sign, e_r[EW-1:0], frac_r[MW-1:0]};
    flg_c = '0;
    flg_c[FLAG_INEXACT] = inexact;

    if (a_nan || b_nan || inf_zero) begin
      res_c = W'(fp_canon_nan(EW, MW));
      flg_c = '0;
      flg_c[FLAG_INVALID] = inf_zero;
    end else if (a_inf || b_inf) begin
      res_c = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
      flg_c = '0;
    end else if (a_zero || b_zero) begin
      res_c = {s2_sign, {(W-1){1'b0}}};
      flg_c = '0;
    end else if (e_r >= E_MAX) begin
      res_c = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
      flg_c = '0;
      flg_c[FLAG_OVERFLOW] = 1'b1;
      flg_c[FLAG_INEXACT]  = 1'b1;
    end else if (e_r[EXW-1] || e_r == '0) begin
      res_c = {s2_sign, {(W-1){1'b0}}};
      flg_c = '0;
      flg_c[FLAG_UNDERFLOW] = 1'b1;
      flg_c[FLAG_INEXACT]   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.flags     <= '0;
    end else if (adv) begin
      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.result <= res_c;
        bus.flags  <= flg_c;
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (half precision) against an integer-arithmetic reference.
module tb_fp_mul_pipe;
  import fp_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  fp_mul_pipe_if #(.EXPONENT_WIDTH(5), .MANTISSA_WIDTH(10)) bus ();

  fp_mul_pipe #(.EXPONENT_WIDTH(5), .MANTISSA_WIDTH(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  logic [19:0] exp_q[$];
  logic [19:0] mon_e;
  bit          stall_prev = 1'b0;
  logic [19:0] held_prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: exact integer product, rounding decided from quotient/remainder.
  function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int  ea, eb, fa, fb, prod, sh, e, q, rem, half;
    bit  s, za, zb, ia, ib, na, nb, inexact;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 31) && (fa == 0); ib = (eb == 31) && (fb == 0);
    na = (ea == 31) && (fa != 0); nb = (eb == 31) && (fb != 0);
    if (na || nb || (ia && zb) || (za && ib))
      return {((ia && zb) || (za && ib)) ? 4'b1000 : 4'b0000, 16'h7E00};
    if (ia || ib) return {4'b0000, s, 15'h7C00};
    if (za || zb) return {4'b0000, s, 15'h0000};
    prod = (1024 + fa) * (1024 + fb);
    sh   = (prod >= (1 << 21)) ? 11 : 10;
    e    = ea + eb - 15 + (sh - 10);
    q    = prod >> sh;
    rem  = prod - (q << sh);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    if (q == 2048) begin q = 1024; e++; end
    inexact = (rem != 0);
    if (e >= 31) return {4'b0101, s, 15'h7C00};
    if (e <= 0)  return {4'b0011, s, 15'h0000};
    return {3'b000, inexact, s, 5'(e), 10'(q - 1024)};
  endfunction

  function automatic logic [15:0] rand_op();
    int r, e, f;
    r = int'($urandom_range(0, 9));
    if (r == 0)      e = 0;
    else if (r == 1) e = 31;
    else if (r == 2) e = int'($urandom_range(0, 31));
    else             e = int'($urandom_range(8, 22));
    f = int'($urandom_range(0, 1023));
    if (e == 31 && $urandom_range(0, 1) == 0) f = 0;
    return {1'($urandom_range(0, 1)), 5'(e), 10'(f)};
  endfunction

  // Scoreboard: inputs captured and outputs consumed at the negedge before the transferring edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev)
        check_eq("stall_hold", {12'h0, bus.flags, bus.result}, {12'h0, held_prev});
      if (bus.out_valid && !bus.out_ready)
        check_eq("stall_in_ready", {31'h0, bus.in_ready}, 32'h0);
      stall_prev = bus.out_valid && !bus.out_ready;
      held_prev  = {bus.flags, bus.result};
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(ref_mul(bus.flp_a, bus.flp_b));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 32'h1, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("sb_result", {16'h0, bus.result}, {16'h0, mon_e[15:0]});
          check_eq("sb_flags",  {28'h0, bus.flags},  {28'h0, mon_e[19:16]});
          n_out++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] want_res, input logic [3:0] want_flg);
    int g, lat;
    logic [19:0] m;
    m = ref_mul(a, b);
    check_eq({tag, "_model"}, {12'h0, m}, {12'h0, want_flg, want_res});
    bus.out_ready = 1'b1;
    bus.flp_a     = a;
    bus.flp_b     = b;
    bus.in_valid  = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 20) begin tick(); g++; end
    if (g >= 20) begin
      check_eq({tag, "_accept_timeout"}, 32'h0, 32'h1);
      bus.in_valid = 1'b0;
      return;
    end
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin tick(); lat++; end
    check_eq({tag, "_latency"}, 32'(lat), 32'd3);
    check_eq({tag, "_result"}, {16'h0, bus.result}, {16'h0, want_res});
    check_eq({tag, "_flags"},  {28'h0, bus.flags},  {28'h0, want_flg});
    tick();
  endtask

  initial begin
    int sent, base, g;
    bit acc;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.flp_a     = '0;
    bus.flp_b     = '0;

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check_eq("rst_result",    {16'h0, bus.result},    32'h0);
    check_eq("rst_flags",     {28'h0, bus.flags},     32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check_eq("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);

    run_one("mul_1p5",  16'h3E00, 16'h3E00, 16'h4080, 4'b0000);
    run_one("rne_down", 16'h3C01, 16'h3C01, 16'h3C02, 4'b0001);
    run_one("rne_tie",  16'h3C01, 16'h3E00, 16'h3E02, 4'b0001);
    run_one("overflow", 16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
    run_one("underflow",16'h0400, 16'h3800, 16'h0000, 4'b0011);
    run_one("inf_zero", 16'h7C00, 16'h0000, 16'h7E00, 4'b1000);
    run_one("neg_zero", 16'h8000, 16'h3C00, 16'h8000, 4'b0000);
    run_one("neg_inf",  16'hFC00, 16'h4000, 16'hFC00, 4'b0000);
    run_one("nan_zero", 16'h7C01, 16'h0000, 16'h7E00, 4'b0000);
    run_one("denorm",   16'h0001, 16'h3C00, 16'h0000, 4'b0000);

    // Back-pressure: six pairs streamed, consumer stalls on cycles 4..7.
    base = n_out;
    sent = 0;
    for (int cyc = 0; cyc < 40 && !(sent == 6 && exp_q.size() == 0); cyc++) begin
      bus.out_ready = !(cyc >= 4 && cyc <= 7);
      if (sent < 6) begin
        bus.in_valid = 1'b1;
        bus.flp_a    = 16'h3C00 + 16'(sent * 37);
        bus.flp_b    = 16'h4100 + 16'(sent * 113);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("bp_sent",   32'(sent), 32'd6);
    check_eq("bp_outs",   32'(n_out - base), 32'd6);
    check_eq("bp_qempty", 32'(exp_q.size()), 32'd0);

    // Reset with two items in flight.
    bus.flp_a = 16'h4200; bus.flp_b = 16'h4400; bus.in_valid = 1'b1;
    tick();
    bus.flp_a = 16'h4500;
    tick();
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check_eq("midrst_result",    {16'h0, bus.result},    32'h0);
    exp_q.delete();
    stall_prev = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check_eq("midrst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    check_eq("midrst_no_stale", {31'h0, bus.out_valid}, 32'h0);
    run_one("post_rst", 16'h4000, 16'h4200, 16'h4600, 4'b0000);

    // Randomized traffic with random back-pressure.
    acc = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.flp_a    = rand_op();
        bus.flp_b    = rand_op();
      end
      #1;
      acc = bus.in_valid && bus.in_ready;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 20) begin tick(); g++; end
    check_eq("rand_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end
endmodule
